vc_inpbuf: RTL and testbench
============================

// Module: vc_inpbuf
// PURPOSE
//  Synchronous per-VC input buffer at a router input port; it is the downstream consumer of a VC output buffer.
//  Accepts flits tagged with a one-hot VC (dit/dovc style) and stores them in one FIFO per VC.
//  Raises per-VC requests to the VC allocator, forwards granted packets flit by flit and returns one credit per dequeued flit.
// PARAMETERS
//  DW     32  flit data width
//  VCN    4   number of virtual channels
//  FT     3   flit type width, one-hot {EOF,BOF,HOF}
//  DEPTH  4   flits per VC FIFO, power of 2, >=2; equals upstream credit count
// PORTS
//  clk     in   1        single clock, rising edge
//  rst     in   1        synchronous, active-high reset
//  di      in   DW       input flit data
//  dit     in   FT       input flit type
//  divc    in   VCN      input VC, one-hot
//  div     in   1        input flit valid; no ready, credit-guaranteed
//  credit  out  VCN      one-cycle credit pulse per VC
//  vcr     out  VCN      VC allocation request (level)
//  vca     in   VCN      VC allocation grant (pulse)
//  do      out  DW       output flit data
//  dot     out  FT       output flit type
//  dovc    out  VCN      output flit VC, one-hot
//  dov     out  1        output valid
//  doa     in   1        output accept; dequeue when dov&doa
//  err     out  1        sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all FIFOs empty, all VC FSMs IDLE, RR pointer = VC0.
//   credit=0, vcr=0, dov=0, dovc=0, do=0, dot=0, err=0.
//  Write: div & divc[v] writes FIFO v at the edge; the flit is visible at the head from the next cycle (1-cycle latency).
//  Write and read of the same VC in one cycle are both performed, including when the FIFO is full or empty.
//  Empty FIFO + write: no bypass; the flit is readable next cycle.
//  Pointers: log2(DEPTH) bits plus a wrap bit; full = indices equal, wrap bits differ.
//  Per-VC FSM:
//   IDLE   -> REQ when the FIFO is non-empty and head dit[0] (HOF) = 1.
//   REQ    vcr[v]=1; -> ACTIVE on vca[v]. vca on a non-REQ VC is ignored.
//   ACTIVE head eligible for output; -> IDLE when a flit with dit[2] (EOF) dequeues.
//  A head flit with HOF|EOF is a single-flit packet: REQ -> ACTIVE -> IDLE after one dequeue.
//  An ACTIVE VC with an empty FIFO waits; it does not return to IDLE.
//  Output select: round-robin over VCs that are ACTIVE and non-empty.
//   Combinational from FIFO heads: dov=1, do/dot = head of winner, dovc = one-hot winner.
//   When dov=0, do/dot/dovc = 0.
//   The RR pointer moves to winner+1 (mod VCN) only on dov&doa; otherwise the selection holds stable.
//  Credit: credit[v] is registered and pulses high in the cycle after each dequeue from VC v.
//   At most one bit is high per cycle.
//  Reset asserted mid-packet clears all state; no credits are returned for discarded flits.
// CONFIGURATION
//  VCIB_PROTCHK_EN defined: err sets (sticky until rst) on any of:
//   - write to a full FIFO with no same-cycle read; the flit is dropped
//   - div with divc not one-hot; the flit is dropped
//   - HOF written to VC v while the previous packet on v has not yet written its EOF
//   - BOF/EOF written to VC v without a preceding HOF on v
//  VCIB_PROTCHK_EN undefined: err tied 0, no checks, no dropping; overflow behaviour is unspecified.
// STRUCTURE
//  Package vc_noc_pkg:
//   FT_HOF=3'b001, FT_BOF=3'b010, FT_EOF=3'b100
//   VC FSM state typedef {VC_IDLE, VC_REQ, VC_ACTIVE}
//   onehot-to-index function
//  Sub-module vc_fifo (#DW+FT, DEPTH): sync FIFO with wr/rd/full/empty/head; one instance per VC.
//  Top level: per-VC FSMs, RR arbiter, output mux, credit register, checker.
// TESTING
//  1 Reset, then 3-flit packet HOF/BOF/EOF on VC1 -> vcr=4'b0010;
//    vca[1] pulse -> dovc=4'b0010 x3 with doa=1; credit[1] pulses 3 times; VC1 back to IDLE.
//  2 Single-flit HOF|EOF (dit=3'b101) on VC0, granted -> one dequeue, credit=4'b0001, vcr[0] deasserts.
//  3 Fill VC2 with DEPTH=4 flits, doa=0 -> FIFO full, no err.
//    Write and read VC2 in the same cycle -> occupancy stays 4, err=0.
//  4 VC0 and VC3 both ACTIVE and non-empty, doa=1 -> output alternates VC0, VC3, VC0...
//    With doa=0, dovc holds.
//  5 rst pulsed mid-packet on VC1 -> next cycle dov=0, vcr=0, credit=0, FIFO empty.
//  6 PROTCHK_EN: 5th write to full VC2 -> err=1 sticky, flit dropped; divc=4'b0011 -> err=1.
//    Without PROTCHK_EN, err stays 0.

Source files
------------

// File: rtl/vc_inpbuf_pkg.sv
// Shared definitions for the VC input buffer: flit type encodings, the per-VC
// allocation state type and a one-hot to index helper.
package vc_noc_pkg;

   localparam logic [2:0] FT_HOF = 3'b001;
   localparam logic [2:0] FT_BOF = 3'b010;
   localparam logic [2:0] FT_EOF = 3'b100;

   typedef enum logic [1:0] {
      VC_IDLE,
      VC_REQ,
      VC_ACTIVE
   } vc_state_t;

   // Index of the highest set bit; callers only pass one-hot vectors.
   function automatic int unsigned oh2idx(input logic [31:0] oh);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/vc_inpbuf_if.sv
// Bundle of all flit, credit, allocation and status signals around the VC
// input buffer. The buffer itself uses the slave modport; the environment
// (upstream output buffer, allocator and downstream consumer) uses master.
//  di/dit/divc/div : incoming flit, type, one-hot VC, valid
//  credit          : one-cycle credit pulse per VC back to upstream
//  vcr/vca         : VC allocation request (level) / grant (pulse)
//  dout/dot/dovc   : outgoing flit data, type, one-hot VC
//  dov/doa         : outgoing valid / accept
//  err             : sticky protocol error
interface vc_inpbuf_if #(
   parameter int DW  = 32,
   parameter int VCN = 4,
   parameter int FT  = 3
);
   logic [DW-1:0]  di;
   logic [FT-1:0]  dit;
   logic [VCN-1:0] divc;
   logic           div;
   logic [VCN-1:0] credit;
   logic [VCN-1:0] vcr;
   logic [VCN-1:0] vca;
   logic [DW-1:0]  dout;
   logic [FT-1:0]  dot;
   logic [VCN-1:0] dovc;
   logic           dov;
   logic           doa;
   logic           err;

   modport master (
      output di, dit, divc, div, vca, doa,
      input  credit, vcr, dout, dot, dovc, dov, err
   );

   modport slave (
      input  di, dit, divc, div, vca, doa,
      output credit, vcr, dout, dot, dovc, dov, err
   );
endinterface

// File: rtl/vc_inpbuf_fifo.sv
// Synchronous FIFO holding one VC's flits ({type, data} words).
//  clk, rst : clock, synchronous active-high reset
//  wr/wdata : push; ignored when full unless a pop happens in the same cycle
//  rd       : pop; ignored when empty
//  full/empty/head : status and combinational head word
// Pointers carry one extra wrap bit: equal indices with differing wrap bits
// means full, fully equal pointers means empty.
module vc_fifo #(
   parameter int W     = 35,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr,
   input  logic [W-1:0] wdata,
   input  logic         rd,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         rd_en;
   logic         wr_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign rd_en = rd & ~empty;
   // A pop in the same cycle frees the slot the push lands in.
   assign wr_en = wr & (~full | rd_en);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/vc_inpbuf.sv
// Per-VC input buffer at a router input port. Flits arrive tagged with a
// one-hot VC and are queued in one FIFO per VC. A VC whose head is a header
// flit requests allocation; once granted its flits compete in a round-robin
// output mux until the tail flit leaves. Each dequeue returns one credit.
//  clk, rst : clock, synchronous active-high reset
//  bus      : vc_inpbuf_if slave (flit in, credit, vcr/vca, flit out, err)
// Build option VCIB_PROTCHK_EN: enables the protocol checker driving err and
// drops flits written to a full FIFO or with a non-one-hot divc. Without it
// err is tied low.
//
// state     | meaning
// VC_IDLE   | no packet owns the VC; waiting for a header at the FIFO head
// VC_REQ    | header at head, vcr raised, waiting for vca
// VC_ACTIVE | granted; head flits eligible for output until the tail leaves
module vc_inpbuf
   import vc_noc_pkg::*;
#(
   parameter int DW    = 32,
   parameter int VCN   = 4,
   parameter int FT    = 3,
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   vc_inpbuf_if.slave bus
);
   localparam int IW = $clog2(VCN);

   logic [VCN-1:0]   fifo_wr;
   logic [VCN-1:0]   fifo_rd;
   logic [VCN-1:0]   full;
   logic [VCN-1:0]   empty;
   logic [VCN-1:0]   elig;
   logic [DW+FT-1:0] head [VCN];
   logic [FT-1:0]    head_ft [VCN];
   vc_state_t        state [VCN];
   logic [VCN-1:0]   vcr_q;
   logic [VCN-1:0]   credit_q;
   logic [IW-1:0]    rr_ptr;
   logic [IW-1:0]    win;
   logic             found;

   always_comb begin
      fifo_wr = '0;
      for (int v = 0; v < VCN; v++) begin
         fifo_wr[v] = bus.div & bus.divc[v] & (~full[v] | fifo_rd[v]);
      end
`ifdef VCIB_PROTCHK_EN
      if (!$onehot(bus.divc)) fifo_wr = '0;
`endif
   end

   for (genvar v = 0; v < VCN; v++) begin : g_vc
      vc_fifo #(.W(DW + FT), .DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .wr    (fifo_wr[v]),
         .wdata ({bus.dit, bus.di}),
         .rd    (fifo_rd[v]),
         .full  (full[v]),
         .empty (empty[v]),
         .head  (head[v])
      );
   end

   always_comb begin
      for (int v = 0; v < VCN; v++) begin
         head_ft[v] = head[v][DW +: FT];
         elig[v]    = (state[v] == VC_ACTIVE) && !empty[v];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < VCN; v++) state[v] <= VC_IDLE;
         vcr_q <= '0;
      end else begin
         for (int v = 0; v < VCN; v++) begin
            case (state[v])
               VC_IDLE: begin
                  if (!empty[v] && |(head_ft[v] & FT_HOF)) begin
                     state[v] <= VC_REQ;
                     vcr_q[v] <= 1'b1;
                  end
               end
               VC_REQ: begin
                  if (bus.vca[v]) begin
                     state[v] <= VC_ACTIVE;
                     vcr_q[v] <= 1'b0;
                  end
               end
               VC_ACTIVE: begin
                  if (fifo_rd[v] && |(head_ft[v] & FT_EOF)) state[v] <= VC_IDLE;
               end
               default: begin
                  state[v] <= VC_IDLE;
                  vcr_q[v] <= 1'b0;
               end
            endcase
         end
      end
   end

   // Search starts at the pointer so the last served VC goes to the back.
   always_comb begin
      int idx;
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < VCN; i++) begin
         idx = (int'(rr_ptr) + i) % VCN;
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = IW'(idx);
         end
      end
   end

   always_comb begin
      bus.dov  = found;
      bus.dout = '0;
      bus.dot  = '0;
      bus.dovc = '0;
      if (found) begin
         {bus.dot, bus.dout} = head[win];
         bus.dovc[win]       = 1'b1;
      end
   end

   assign fifo_rd = (found && bus.doa) ? bus.dovc : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= '0;
         credit_q <= '0;
      end else begin
         credit_q <= fifo_rd;
         if (found && bus.doa) rr_ptr <= IW'((int'(win) + 1) % VCN);
      end
   end

   assign bus.credit = credit_q;
   assign bus.vcr    = vcr_q;

`ifdef VCIB_PROTCHK_EN
   logic           err_q;
   logic [VCN-1:0] in_pkt;
   logic [IW-1:0]  wr_idx;
   logic           w_hof;
   logic           w_bof;
   logic           w_eof;

   assign wr_idx = IW'(oh2idx(32'(bus.divc)));
   assign w_hof  = |(bus.dit & FT_HOF);
   assign w_bof  = |(bus.dit & FT_BOF);
   assign w_eof  = |(bus.dit & FT_EOF);

   // in_pkt[v]: a header was accepted on v and its tail has not been written.
   // Only accepted flits move it; dropped flits leave the packet view as-is.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q  <= 1'b0;
         in_pkt <= '0;
      end else if (bus.div) begin
         if (!$onehot(bus.divc)) begin
            err_q <= 1'b1;
         end else begin
            if (full[wr_idx] && !fifo_rd[wr_idx]) err_q <= 1'b1;
            if (w_hof && in_pkt[wr_idx]) err_q <= 1'b1;
            if (!w_hof && (w_bof || w_eof) && !in_pkt[wr_idx]) err_q <= 1'b1;
            if (fifo_wr[wr_idx]) begin
               if (w_eof)      in_pkt[wr_idx] <= 1'b0;
               else if (w_hof) in_pkt[wr_idx] <= 1'b1;
            end
         end
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_vc_inpbuf.sv
`timescale 1ns/1ps
module tb_vc_inpbuf;
   import vc_noc_pkg::*;

   localparam int DW    = 32;
   localparam int VCN   = 4;
   localparam int FT    = 3;
   localparam int DEPTH = 4;

   typedef logic [FT+DW-1:0] flit_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vc_inpbuf_if #(.DW(DW), .VCN(VCN), .FT(FT)) bus ();

   vc_inpbuf #(.DW(DW), .VCN(VCN), .FT(FT), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Per-VC queues hold every accepted flit (the expected output stream).
   // Packet state per VC: 0 = free, 1 = waiting for grant, 2 = granted.
   flit_t          mq [VCN][$];
   int             mst [VCN];
   int             nst [VCN];
   bit             mpkt [VCN];
   int             mrr;
   logic [VCN-1:0] mcred;
   bit             merr;
   bit             mvalid = 1'b0;
   int             xfer_cnt = 0;

   int             w, v, wv;
   flit_t          f, pf;
   logic [VCN-1:0] evcr, edovc, ncred;
   logic [DW-1:0]  edo;
   logic [FT-1:0]  edot;
   bit             xfer, mfull, hof, bof, eof;

   always @(negedge clk) begin
      w = -1;
      for (int i = 0; i < VCN; i++) begin
         v = (mrr + i) % VCN;
         if (w < 0 && mst[v] == 2 && mq[v].size() > 0) w = v;
      end
      if (mvalid) begin
         edovc = '0; edo = '0; edot = '0;
         if (w >= 0) begin
            f = mq[w][0];
            edovc[w] = 1'b1;
            edo  = f[DW-1:0];
            edot = f[DW+FT-1:DW];
         end
         for (int i = 0; i < VCN; i++) evcr[i] = (mst[i] == 1);
         chk("dov", 64'(bus.dov), 64'(w >= 0));
         chk("dovc", 64'(bus.dovc), 64'(edovc));
         chk("do", 64'(bus.dout), 64'(edo));
         chk("dot", 64'(bus.dot), 64'(edot));
         chk("vcr", 64'(bus.vcr), 64'(evcr));
         chk("credit", 64'(bus.credit), 64'(mcred));
         chk("err", 64'(bus.err), 64'(merr));
      end
      if (rst) begin
         for (int i = 0; i < VCN; i++) begin
            mq[i].delete();
            mst[i]  = 0;
            mpkt[i] = 1'b0;
         end
         mrr = 0; mcred = '0; merr = 1'b0;
         mvalid = 1'b1;
      end else if (mvalid) begin
         for (int i = 0; i < VCN; i++) begin
            nst[i] = mst[i];
            if (mst[i] == 0 && mq[i].size() > 0) begin
               f = mq[i][0];
               if (f[DW]) nst[i] = 1;
            end else if (mst[i] == 1 && bus.vca[i]) begin
               nst[i] = 2;
            end
         end
         ncred = '0;
         xfer = (w >= 0) && bus.doa;
         if (xfer) begin
            pf = mq[w].pop_front();
            ncred[w] = 1'b1;
            if (pf[DW+2]) nst[w] = 0;
            mrr = (w + 1) % VCN;
            xfer_cnt++;
         end
         if (bus.div) begin
            if ($onehot(bus.divc)) begin
               wv = 0;
               for (int i = 0; i < VCN; i++) if (bus.divc[i]) wv = i;
               hof = bus.dit[0]; bof = bus.dit[1]; eof = bus.dit[2];
               mfull = (mq[wv].size() == DEPTH);
`ifdef VCIB_PROTCHK_EN
               if (mfull) merr = 1'b1;
               if (hof && mpkt[wv]) merr = 1'b1;
               if (!hof && (bof || eof) && !mpkt[wv]) merr = 1'b1;
               if (!mfull) begin
                  mq[wv].push_back({bus.dit, bus.di});
                  if (eof) mpkt[wv] = 1'b0;
                  else if (hof) mpkt[wv] = 1'b1;
               end
`else
               if (!mfull) mq[wv].push_back({bus.dit, bus.di});
`endif
            end else begin
`ifdef VCIB_PROTCHK_EN
               merr = 1'b1;
`endif
            end
         end
         for (int i = 0; i < VCN; i++) mst[i] = nst[i];
         mcred = ncred;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.div  = 1'b0;
      bus.divc = '0;
      bus.di   = '0;
      bus.dit  = '0;
      bus.vca  = '0;
   endtask

   task automatic put(int vc, logic [2:0] ft, logic [DW-1:0] d);
      bus.div  = 1'b1;
      bus.divc = VCN'(1 << vc);
      bus.dit  = ft;
      bus.di   = d;
      tick();
      clr();
   endtask

   task automatic grant(logic [VCN-1:0] g);
      bus.vca = g;
      tick();
      bus.vca = '0;
   endtask

   task automatic wait_vcr(int vc);
      int n;
      n = 0;
      while (!bus.vcr[vc] && n < 20) begin
         tick();
         n++;
      end
      chk($sformatf("vcr_rise_vc%0d", vc), 64'(bus.vcr[vc]), 64'd1);
   endtask

   task automatic count_credit(int vc, int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         if (bus.credit[vc]) cnt++;
         tick();
      end
   endtask

   int cnt_c;
   int ccount [VCN];
   int rem [VCN];
   int len, rv, sv;
   logic [2:0] ft;

   initial begin
      clr();
      bus.doa = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // 3-flit packet on VC1
      put(1, FT_HOF, 32'h1111_0001);
      put(1, FT_BOF, 32'h1111_0002);
      put(1, FT_EOF, 32'h1111_0003);
      @(negedge clk);
      chk("t1_vcr", 64'(bus.vcr), 64'h2);
      tick();
      bus.doa = 1'b1;
      grant(4'b0010);
      count_credit(1, 8, cnt_c);
      chk("t1_credits", 64'(cnt_c), 64'd3);

      // single-flit packet on VC0
      put(0, 3'b101, 32'h0000_00AA);
      wait_vcr(0);
      grant(4'b0001);
      count_credit(0, 6, cnt_c);
      chk("t2_credits", 64'(cnt_c), 64'd1);
      @(negedge clk);
      chk("t2_vcr", 64'(bus.vcr), 64'h0);
      tick();

      // fill VC2, then simultaneous read and write while full
      bus.doa = 1'b0;
      put(2, FT_HOF, 32'h2222_0000);
      for (int i = 1; i < DEPTH; i++) put(2, FT_BOF, 32'h2222_0000 + i);
      wait_vcr(2);
      grant(4'b0100);
      bus.doa = 1'b1;
      put(2, FT_BOF, 32'h2222_0010);
      bus.doa = 1'b0;
      @(negedge clk);
      chk("t3_err", 64'(bus.err), 64'h0);
      tick();

`ifdef VCIB_PROTCHK_EN
      put(2, FT_BOF, 32'hDEAD_0001);
      bus.div = 1'b1; bus.divc = 4'b0011; bus.dit = FT_BOF; bus.di = 32'hDEAD_0002;
      tick();
      clr();
      @(negedge clk);
      chk("t6_err_set", 64'(bus.err), 64'h1);
      tick();
      repeat (3) tick();
      @(negedge clk);
      chk("t6_err_sticky", 64'(bus.err), 64'h1);
      tick();
`else
      @(negedge clk);
      chk("t6_err_tied", 64'(bus.err), 64'h0);
      tick();
`endif

      // drain VC2 and close its packet
      bus.doa = 1'b1;
      repeat (6) tick();
      put(2, FT_EOF, 32'h2222_00FF);
      repeat (4) tick();

      // VC0 and VC3 compete
      bus.doa = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ft = (i == 0) ? FT_HOF : ((i == 2) ? FT_EOF : FT_BOF);
         put(0, ft, 32'h0A00_0000 + i);
         put(3, ft, 32'h3A00_0000 + i);
      end
      wait_vcr(0);
      wait_vcr(3);
      grant(4'b1001);
      bus.doa = 1'b1;
      repeat (3) tick();
      bus.doa = 1'b0;
      repeat (3) tick();
      bus.doa = 1'b1;
      repeat (6) tick();

      // reset mid-packet on VC1
      put(1, FT_HOF, 32'h5555_0001);
      put(1, FT_BOF, 32'h5555_0002);
      put(1, FT_BOF, 32'h5555_0003);
      wait_vcr(1);
      grant(4'b0010);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_dov", 64'(bus.dov), 64'h0);
      chk("t5_vcr", 64'(bus.vcr), 64'h0);
      chk("t5_credit", 64'(bus.credit), 64'h0);
      tick();

      // randomized legal traffic, upstream limited by returned credits
      for (int i = 0; i < VCN; i++) begin
         ccount[i] = DEPTH;
         rem[i] = 0;
      end
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < VCN; i++) if (bus.credit[i]) ccount[i]++;
         clr();
         bus.doa = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < VCN; i++) if (bus.vcr[i] && $urandom_range(0, 2) == 0) bus.vca[i] = 1'b1;
         if ($urandom_range(0, 15) == 0) begin
            sv = $urandom_range(0, VCN - 1);
            bus.vca[sv] = 1'b1;
         end
         if ($urandom_range(0, 9) < 7) begin
            rv = $urandom_range(0, VCN - 1);
            if (ccount[rv] > 0) begin
               if (rem[rv] == 0) begin
                  len = $urandom_range(1, 4);
                  if (len == 1) ft = 3'b101;
                  else begin
                     ft = FT_HOF;
                     rem[rv] = len - 1;
                  end
               end else begin
                  ft = (rem[rv] == 1) ? FT_EOF : FT_BOF;
                  rem[rv]--;
               end
               ccount[rv]--;
               bus.div  = 1'b1;
               bus.divc = VCN'(1 << rv);
               bus.dit  = ft;
               bus.di   = $urandom;
            end
         end
         tick();
      end

      // drain
      for (int c = 0; c < 300; c++) begin
         clr();
         bus.doa = 1'b1;
         bus.vca = bus.vcr;
         tick();
      end
      clr();
      @(negedge clk);
      chk("final_dov", 64'(bus.dov), 64'h0);
      chk("traffic_seen", 64'(xfer_cnt > 200), 64'h1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
